// File: rtl/comp_pkg.sv
// Shared definitions for the completion writeback path: default widths,
// FSM state encoding and the status-word layout written back to memory.
package comp_pkg;

    localparam int ADDRW_DEF = 24;
    localparam int DATAW_DEF = 32;
    localparam logic [23:0] STATUS_OFF_DEF = 24'h000004;

    // Width of the coalescing counter; COAL is limited to 1..255.
    localparam int PEND_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic [7:0]  TAG_HI = 8'hC0;
    localparam logic [15:0] TAG_LO = 16'h0001;

    function automatic logic [31:0] status_word(input logic [7:0] seq);
        return {TAG_HI, seq, TAG_LO};
    endfunction

endpackage

// File: rtl/comp_irq_coalesce.sv
// Coalesces completion pulses into a level interrupt and tracks the sticky
// grant-timeout flag; both are cleared by the host through irq_clr.
module comp_irq_coalesce
    import comp_pkg::*;
#(
    parameter int COAL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic done,
    input  logic tmo,
    input  logic irq_clr,
    output logic irq,
    output logic err
);

    localparam logic [PEND_W-1:0] COAL_LAST = PEND_W'(COAL - 1);

    logic [PEND_W-1:0] pending;
    logic              hit;

    assign hit = done && (pending == COAL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (done) begin
            pending <= hit ? '0 : pending + 1'b1;
        end
    end

    // A threshold crossing in the same cycle as a host clear keeps irq set,
    // so no interrupt is ever lost to a racing clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (hit) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (tmo) begin
            err <= 1'b1;
        end else if (irq_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: rtl/comp_writeback.sv
// Turns each completion address into one status-word write on the shared
// memory port, counts completions and guards against a hung grant.
module comp_writeback
    import comp_pkg::*;
#(
    parameter int               ADDRW      = ADDRW_DEF,
    parameter int               DATAW      = DATAW_DEF,
    parameter logic [ADDRW-1:0] STATUS_OFF = ADDRW'(STATUS_OFF_DEF),
    parameter int               COAL       = 4,
    parameter int               TMO        = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [ADDRW-1:0] data_in,
    output logic             ready_out,
    output logic             wr_req,
    output logic [ADDRW-1:0] wr_addr,
    output logic [DATAW-1:0] wr_data,
    input  logic             wr_gnt,
    output logic             irq,
    input  logic             irq_clr,
    output logic [15:0]      comp_count,
    output logic             err,
    output logic [ADDRW-1:0] err_addr
);

    localparam int           TW       = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    seq;
    logic          done_pulse;
    logic          tmo_pulse;

    // ready_out is a strobe back to comp_queue: an item moves only on a
    // clock edge where both valid_in and ready_out are high.
    assign ready_out  = (state == IDLE);
    assign done_pulse = (state == DONE);
    // The grant is checked first, so a grant on the last allowed cycle wins.
    assign tmo_pulse  = (state == REQ) && !wr_gnt && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            tmo_cnt    <= '0;
            seq        <= '0;
            comp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        wr_addr <= data_in + STATUS_OFF;
                        wr_data <= DATAW'(status_word(seq));
                        wr_req  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (wr_gnt) begin
                        wr_req <= 1'b0;
                        state  <= DONE;
                    end else if (tmo_pulse) begin
                        wr_req <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    comp_count <= comp_count + 16'd1;
                    seq        <= seq + 8'd1;
                    state      <= IDLE;
                end
                default: begin
                    wr_req <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Only the first timed-out address is kept until the host clears err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_addr <= '0;
        end else if (tmo_pulse && !err) begin
            err_addr <= wr_addr;
        end
    end

    comp_irq_coalesce #(
        .COAL (COAL)
    ) u_coalesce (
        .clk     (clk),
        .rst_n   (rst_n),
        .done    (done_pulse),
        .tmo     (tmo_pulse),
        .irq_clr (irq_clr),
        .irq     (irq),
        .err     (err)
    );

endmodule

// File: tb/tb_comp_writeback.sv
// Directed-plus-random bench for comp_writeback against a transaction-level
// model of completions, coalescing and timeouts.
module tb_comp_writeback;

    localparam int COAL = 4;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [23:0] data_in = '0;
    logic        ready_out;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_gnt = 1'b0;
    logic        irq;
    logic        irq_clr = 1'b0;
    logic [15:0] comp_count;
    logic        err;
    logic [23:0] err_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level model state
    int          m_count;
    int          m_seq;
    int          m_pending;
    bit          m_irq;
    bit          m_err;
    logic [23:0] m_err_addr;

    comp_writeback #(
        .COAL (COAL),
        .TMO  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_out  (ready_out),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .irq        (irq),
        .irq_clr    (irq_clr),
        .comp_count (comp_count),
        .err        (err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count    = 0;
        m_seq      = 0;
        m_pending  = 0;
        m_irq      = 0;
        m_err      = 0;
        m_err_addr = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, ready_out, 1'b1);
        chk({tag, "_wr_req"}, wr_req, 1'b0);
        chk({tag, "_count"}, comp_count, 16'(m_count));
        chk({tag, "_irq"}, irq, m_irq);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_err_addr"}, err_addr, m_err_addr);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready_out && n < 100) begin
            step();
            n++;
        end
        chk("wait_ready_timeout", ready_out, 1'b1);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        wr_gnt = 1'b1;
        repeat (3) step();
        rst_n    = 1'b1;
        wr_gnt   = 1'b0;
        valid_in = 1'b0;
        irq_clr  = 1'b0;
        model_reset();
        chk("rst_wr_addr", wr_addr, 24'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        check_idle_outputs("rst");
    endtask

    // One completion whose grant arrives after dly grantless REQ cycles
    // (dly < TMO). Junk valid_in is held while busy and must be ignored.
    task automatic send_item(input logic [23:0] addr, input int dly, input bit clr_at_done);
        logic [23:0] exp_a;
        logic [31:0] exp_d;
        exp_a = addr + 24'd4;
        exp_d = {8'hC0, 8'(m_seq), 16'h0001};
        wait_ready();
        valid_in = 1'b1;
        data_in  = addr;
        wr_gnt   = 1'b0;
        step();
        data_in = 24'($urandom);
        chk("req_wr_req", wr_req, 1'b1);
        chk("req_wr_addr", wr_addr, exp_a);
        chk("req_wr_data", wr_data, exp_d);
        chk("req_ready", ready_out, 1'b0);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("hold_wr_req", wr_req, 1'b1);
            chk("hold_wr_addr", wr_addr, exp_a);
            chk("hold_wr_data", wr_data, exp_d);
            chk("hold_ready", ready_out, 1'b0);
        end
        wr_gnt = 1'b1;
        step();
        wr_gnt  = 1'b0;
        irq_clr = clr_at_done;
        chk("done_wr_req", wr_req, 1'b0);
        chk("done_ready", ready_out, 1'b0);
        step();
        irq_clr  = 1'b0;
        valid_in = 1'b0;
        if (clr_at_done) begin
            m_irq = 0;
            m_err = 0;
        end
        m_count++;
        m_seq = (m_seq + 1) % 256;
        m_pending++;
        if (m_pending == COAL) begin
            m_pending = 0;
            m_irq     = 1;
        end
        check_idle_outputs("post_done");
    endtask

    task automatic send_timeout(input logic [23:0] addr);
        wait_ready();
        valid_in = 1'b1;
        data_in  = addr;
        wr_gnt   = 1'b0;
        step();
        valid_in = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            step();
            if (i == TMO - 1) chk("tmo_last_req", wr_req, 1'b1);
        end
        step();
        if (!m_err) m_err_addr = addr + 24'd4;
        m_err = 1;
        check_idle_outputs("tmo");
    endtask

    task automatic pulse_clr();
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        m_irq = 0;
        m_err = 0;
        check_idle_outputs("clr");
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single completion, then a delayed grant with ignored valid_in
        send_item(24'h000100, 0, 1'b0);
        send_item(24'h123456, 10, 1'b0);

        // Four back-to-back completions with immediate grant
        repeat (4) send_item(24'($urandom), 0, 1'b0);
        pulse_clr();
        repeat (3) send_item(24'($urandom), 0, 1'b0);

        // Timeout, grant on the very last allowed cycle, second timeout
        send_timeout(24'hABCDEF);
        send_item(24'h000200, 0, 1'b0);
        send_item(24'h000300, TMO - 1, 1'b0);
        send_timeout(24'h00FF00);
        pulse_clr();

        // Random mix of addresses, grant delays and clear-at-done
        for (int i = 0; i < 20; i++) begin
            send_item(24'($urandom), int'($urandom_range(0, 12)), bit'($urandom_range(0, 3) == 0));
        end

        // Address wrap on a threshold-crossing completion with a racing clear
        while (m_pending != COAL - 1) send_item(24'($urandom), 0, 1'b0);
        send_item(24'hFFFFFE, 0, 1'b1);
        chk("wrap_irq_held", irq, 1'b1);

        // Reset while a write is outstanding
        wait_ready();
        valid_in = 1'b1;
        data_in  = 24'h000400;
        step();
        valid_in = 1'b0;
        step();
        chk("pre_rst_wr_req", wr_req, 1'b1);
        do_reset();
        send_item(24'h000500, 2, 1'b0);
        chk("post_rst_count", comp_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/comp_writeback.md
Name: comp_writeback

Overview:
- Consumes the merged completion-address stream from comp_queue: one destination address per finished AES/SHA job.
- For each address it issues one status-word write on the shared memory write port.
- Counts completions and raises a coalesced interrupt to the host.
- Covers grant timeout with an error flag, so a hung bus cannot deadlock the completion path.

Parameters:
- ADDRW, 24, address width; matches comp_queue.
- DATAW, 32, status word width.
- STATUS_OFF, 24'h000004, byte offset added to the destination address to form the status word address.
- COAL, 4, completions per interrupt; legal range 1..255.
- TMO, 64, maximum cycles to wait for wr_gnt; minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  completion address valid (from comp_queue valid_out)
- data_in  in  ADDRW  completion destination address (from comp_queue data_out)
- ready_out  out  1  accept strobe back to comp_queue ready_in
- wr_req  out  1  status write request
- wr_addr  out  ADDRW  status write address
- wr_data  out  DATAW  status word
- wr_gnt  in  1  one-cycle write accept from the bus arbiter
- irq  out  1  level interrupt; held until irq_clr
- irq_clr  in  1  one-cycle interrupt clear from the host CSR
- comp_count  out  16  total successful writebacks; wraps
- err  out  1  sticky grant-timeout flag; cleared by irq_clr
- err_addr  out  ADDRW  wr_addr of the first timed-out write

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, ready_out=1, wr_req=0, wr_addr=0, wr_data=0.
  - irq=0, comp_count=0, err=0, err_addr=0.
  - pending counter=0, sequence counter seq=0.
  - Reset mid-write drops the in-flight write, with no grant or count.
- FSM states are IDLE, REQ, DONE.
- IDLE:
  - ready_out=1.
  - On valid_in&ready_out at edge N, latch wr_addr=(data_in+STATUS_OFF) mod 2^ADDRW.
  - In the same edge latch wr_data={8'hC0, seq[7:0], 16'h0001} and go to REQ.
- REQ:
  - ready_out=0, wr_req=1 from cycle N+1.
  - wr_addr and wr_data stay stable until granted.
  - On wr_gnt: wr_req=0 at the next edge, go to DONE.
  - Timeout counter starts at 0 on entry and increments each REQ cycle without a grant.
  - At TMO cycles without a grant: wr_req=0, err=1, err_addr=wr_addr if err was 0. No count or pending update; go to IDLE.
  - A wr_gnt arriving in the same cycle as the timeout counter reaching TMO counts as a grant; the grant wins.
- DONE (one cycle, ready_out=0):
  - comp_count+=1 and seq+=1, both wrapping.
  - pending+=1; if pending reaches COAL, set irq=1 and pending=0.
  - Return to IDLE.
- Throughput and latency:
  - With wr_gnt arriving in the first REQ cycle, an item is accepted at edge N.
  - wr_req is high from N+1 to N+2, DONE occurs at N+2, and the next accept happens at N+3: one item per 3 cycles.
- irq_clr:
  - Clears irq and err at the next edge; leaves pending untouched.
  - If irq_clr and a DONE-cycle threshold crossing occur in the same cycle, set wins and irq stays 1.
- irq_clr does not affect comp_count.
- valid_in while ready_out=0 is ignored; comp_queue holds the data.
- Address arithmetic truncates to ADDRW; an address of 24'hFFFFFE plus offset 4 wraps to 24'h000002.

Decomposition:
- A shared package comp_pkg holds:
  - ADDRW and DATAW defaults;
  - the state enum {IDLE, REQ, DONE};
  - the status-word tag constants (8'hC0, 16'h0001).
- One natural sub-module: comp_irq_coalesce.
  - Contains the pending counter, threshold compare and irq/err set-clear priority.
  - Driven by the FSM's done and timeout pulses.
- The FSM and datapath stay in comp_writeback.

Test Plan:
- Single completion:
  - Stimulus: data_in=24'h000100 with wr_gnt tied 1.
  - Response: wr_req for one cycle with wr_addr=24'h000104 and wr_data=32'hC0000001; comp_count=1; irq stays 0.
- Grant delay:
  - Stimulus: wr_gnt held off for 10 cycles.
  - Response: wr_req, wr_addr and wr_data stable for 10 cycles; ready_out=0 throughout; a second valid_in is not accepted until after DONE.
- Coalescing:
  - Stimulus: 4 back-to-back completions with immediate grant.
  - Response: seq bytes 00..03 in wr_data; irq rises in the cycle after the 4th DONE.
  - Follow-up: irq_clr pulse gives irq=0; 3 more completions keep irq=0.
- Timeout:
  - Stimulus: wr_gnt=0 for data_in=24'hABCDEF.
  - Response: after 64 cycles wr_req=0, err=1, err_addr=24'hABCDF3, comp_count unchanged.
  - Follow-up: the next item is accepted normally.
- Wrap and priority:
  - Stimulus: data_in=24'hFFFFFE, and irq_clr in the same cycle as a threshold-crossing DONE.
  - Response: wr_addr=24'h000002 and irq=1.
- Reset mid-REQ:
  - Stimulus: rst_n low for 3 cycles while wr_req=1.
  - Response: all outputs at reset values; no grant is counted; the bench replays the next item and sees seq=0.
